// File: rtl/answer_poller_pkg.sv
// Shared types and constants for the answer poller and its content checker.
package answer_pkg;
    localparam int NUM_SLOTS = 20;
    localparam int SLOT_STEP = 10;
    localparam int ADDR_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POLL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/answer_poller_if.sv
// Responder address/data bus plus the drained-byte valid/ready stream.
interface answer_poller_if;
    import answer_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_in;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output addr, out_data, out_valid, out_last,
                    input  data_in, out_ready);
    modport slave  (input  addr, out_data, out_valid, out_last,
                    output data_in, out_ready);
endinterface

// File: rtl/answer_poller_checker.sv
// Content checker for captured slot bytes; exists only when CONTENT_CHECK_EN is defined.
`ifdef CONTENT_CHECK_EN
module answer_checker
    import answer_pkg::*;
(
    input  logic              clk80MHz,
    input  logic              rst,
    input  logic              cap_vld,
    input  logic [ADDR_W-1:0] cap_idx,
    input  logic [7:0]        cap_data,
    output logic              err,
    output logic [7:0]        err_cnt
);
    logic       first;
    logic [7:0] prev0;
    logic [7:0] expect_b;
    logic       mis;

    // Slot 0 carries the responder's frame counter; it cannot be judged until one frame is seen.
    always_comb begin
        expect_b = 8'(int'(cap_idx) * SLOT_STEP);
        if (cap_idx == '0)
            expect_b = prev0 + 8'd1;
        mis = cap_vld && !(cap_idx == '0 && first) && (cap_data != expect_b);
    end

    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            first   <= 1'b1;
            prev0   <= 8'd0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (cap_vld && cap_idx == '0) begin
                first <= 1'b0;
                prev0 <= cap_data;
            end
            if (mis) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule
`endif

// File: rtl/answer_poller.sv
// Polls NUM_SLOTS responder addresses per frame, buffers the answers and drains them as a stream.
// Optional byte content checking is enabled with CONTENT_CHECK_EN.
module answer_poller
    import answer_pkg::*;
#(
    parameter int                NUM_SLOTS = answer_pkg::NUM_SLOTS,
    parameter int                RD_LAT    = 2,
    parameter logic [ADDR_W-1:0] PARK_ADDR = '0
) (
    input  logic               clk80MHz,
    input  logic               rst,
    input  logic               start,
    answer_poller_if.master    bus,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic               err,
    output logic [7:0]         err_cnt
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SLOTS - 1);

    state_t state, state_n;

    logic                          iss_on;
    logic [RD_LAT:1]               vld_pipe;
    logic [RD_LAT:1][ADDR_W-1:0]   tag_pipe;
    logic [7:0]                    buffer [NUM_SLOTS];
    logic [ADDR_W-1:0]             rptr;

    logic              cap_vld;
    logic [ADDR_W-1:0] cap_idx;
    logic              cap_last;
    logic              xfer;

    assign cap_vld  = vld_pipe[RD_LAT];
    assign cap_idx  = tag_pipe[RD_LAT];
    assign cap_last = cap_vld && (cap_idx == LAST);

    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        xfer    = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_n = ST_POLL;
            ST_POLL:  if (cap_last) state_n = ST_DRAIN;
            ST_DRAIN: begin
                xfer = bus.out_valid && bus.out_ready;
                if (xfer && rptr == LAST) state_n = ST_IDLE;
            end
            default:  state_n = ST_IDLE;
        endcase
    end

    // The last address is held for a single cycle: the responder bumps its counter per sample.
    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            bus.addr      <= PARK_ADDR;
            iss_on        <= 1'b0;
            vld_pipe      <= '0;
            tag_pipe      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= 8'd0;
            rptr          <= '0;
            busy          <= 1'b0;
            frame_cnt     <= 16'd0;
        end else begin
            busy <= (state_n != ST_IDLE);

            if (state == ST_IDLE && start) begin
                iss_on   <= 1'b1;
                bus.addr <= '0;
            end else if (iss_on && bus.addr == LAST) begin
                iss_on   <= 1'b0;
                bus.addr <= PARK_ADDR;
            end else if (iss_on) begin
                bus.addr <= bus.addr + 1'b1;
            end

            vld_pipe[1] <= iss_on;
            tag_pipe[1] <= bus.addr;
            for (int j = 2; j <= RD_LAT; j++) begin
                vld_pipe[j] <= vld_pipe[j-1];
                tag_pipe[j] <= tag_pipe[j-1];
            end

            if (state == ST_POLL && cap_last) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= (NUM_SLOTS == 1) ? bus.data_in : buffer[0];
                bus.out_last  <= (NUM_SLOTS == 1);
                rptr          <= '0;
            end else if (xfer) begin
                if (rptr == LAST) begin
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    frame_cnt     <= frame_cnt + 16'd1;
                end else begin
                    rptr          <= rptr + 1'b1;
                    bus.out_data  <= buffer[rptr + 1'b1];
                    bus.out_last  <= ((rptr + 1'b1) == LAST);
                end
            end
        end
    end

    always_ff @(posedge clk80MHz) begin
        if (cap_vld) buffer[cap_idx] <= bus.data_in;
    end

`ifdef CONTENT_CHECK_EN
    answer_checker u_chk (
        .clk80MHz (clk80MHz),
        .rst      (rst),
        .cap_vld  (cap_vld),
        .cap_idx  (cap_idx),
        .cap_data (bus.data_in),
        .err      (err),
        .err_cnt  (err_cnt)
    );
`else
    assign err     = 1'b0;
    assign err_cnt = 8'd0;
`endif
endmodule
